// File: rtl/gray_checker_pkg.sv
// gray_checker_pkg: shared Gray-code constants, FSM state encoding and fault codes for gray_checker
package gray_pkg;
  localparam logic [2:0] S0 = 3'b000;
  localparam logic [2:0] S1 = 3'b001;
  localparam logic [2:0] S2 = 3'b011;
  localparam logic [2:0] S3 = 3'b010;
  localparam logic [2:0] S4 = 3'b110;
  localparam logic [2:0] S5 = 3'b111;
  localparam logic [2:0] S6 = 3'b101;
  localparam logic [2:0] S7 = 3'b100;
  typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;
  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_START = 2'b01;
  localparam logic [1:0] ERR_JUMP  = 2'b10;
  localparam logic [1:0] ERR_OVF   = 2'b11;
endpackage

// File: rtl/gray_checker_gray2bin.sv
// gray2bin: 3-bit Gray to binary converter; ports gray (in), bin (out)
module gray2bin (
  input  logic [2:0] gray,
  output logic [2:0] bin
);
  always_comb begin
    bin[2] = gray[2];
    bin[1] = bin[2] ^ gray[1];
    bin[0] = bin[1] ^ gray[0];
  end
endmodule

// File: rtl/gray_checker.sv
// gray_checker: monitors a 3-bit Gray counter (Clk, Reset, Gray, Ovf_in in; Bin, Step, Down, Wrap_cnt, Err, Err_code out); GRAY_CHECKER_BIDIR_EN allows backward steps
module gray_checker
  import gray_pkg::*;
#(
  parameter int WRAP_W = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [2:0]        Gray,
  input  logic              Ovf_in,
  output logic [2:0]        Bin,
  output logic              Step,
  output logic              Down,
  output logic [WRAP_W-1:0] Wrap_cnt,
  output logic              Err,
  output logic [1:0]        Err_code
);
  state_t state;
  logic [2:0] prev, prev_bin, gray_bin, nxt_bin;
  logic ovf_prev, fwd, wrap, ovf_chg;
  gray2bin u_prev (.gray(prev), .bin(prev_bin));
  gray2bin u_cur (.gray(Gray), .bin(gray_bin));
  always_comb begin
    nxt_bin = prev_bin + 3'd1;
    fwd     = gray_bin == nxt_bin;
    wrap    = prev == S7 && Gray == S0;
    ovf_chg = Ovf_in != ovf_prev;
  end
`ifdef GRAY_CHECKER_BIDIR_EN
  logic [2:0] prv_bin;
  logic bwd;
  always_comb begin
    prv_bin = prev_bin - 3'd1;
    bwd     = gray_bin == prv_bin;
  end
`endif
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= SYNC;
      prev     <= S0;
      ovf_prev <= 1'b0;
      Bin      <= 3'd0;
      Step     <= 1'b0;
      Down     <= 1'b0;
      Wrap_cnt <= '0;
      Err      <= 1'b0;
      Err_code <= ERR_NONE;
    end else begin
      ovf_prev <= Ovf_in;
      Step     <= 1'b0;
      Down     <= 1'b0;
      case (state)
        SYNC:
          if (Gray == S0 && !Ovf_in) state <= TRACK;
          else begin
            state    <= FAULT;
            Err      <= 1'b1;
            Err_code <= ERR_START;
          end
        TRACK:
          // only the wrap may move Overflow, and the wrap must raise it on the same edge
          if ((ovf_chg && !wrap) || (wrap && !Ovf_in)) begin
            state    <= FAULT;
            Err      <= 1'b1;
            Err_code <= ERR_OVF;
          end else if (Gray == prev) begin
          end else if (fwd) begin
            Step <= 1'b1;
            Bin  <= gray_bin;
            prev <= Gray;
            if (wrap && Wrap_cnt != '1) Wrap_cnt <= Wrap_cnt + WRAP_W'(1);
          end
`ifdef GRAY_CHECKER_BIDIR_EN
          else if (bwd) begin
            Down <= 1'b1;
            Bin  <= gray_bin;
            prev <= Gray;
          end
`endif
          else begin
            state    <= FAULT;
            Err      <= 1'b1;
            Err_code <= ERR_JUMP;
          end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/gray_checker.md
Name: gray_checker

Overview:
- Downstream monitor for the 3-bit Gray counter. Consumes the counter's `Output` and `Overflow` on every clock.
- Checks that every change is a legal single Gray step and converts the code to binary.
- Pulses on each advance, counts wrap-arounds and latches a sticky fault with a cause code.
- Sits directly after the counter. Drives display and self-check logic.

Parameters:
- WRAP_W, 4, width of the wrap counter; saturates at 2^WRAP_W-1.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- Gray  input  3  Gray code from the counter's Output.
- Ovf_in  input  1  counter's Overflow flag.
- Bin  output  3  registered binary equivalent of the last accepted Gray value.
- Step  output  1  one-cycle pulse on each accepted forward step.
- Down  output  1  one-cycle pulse on each accepted backward step; tied 0 without the optional feature.
- Wrap_cnt  output  WRAP_W  number of accepted 100->000 wraps, saturating.
- Err  output  1  sticky fault flag.
- Err_code  output  2  fault cause: 00 none, 01 bad start, 10 illegal jump, 11 overflow mismatch.

Behaviour:
- Reset, sampled at posedge:
  - Bin=0, Step=0, Down=0, Wrap_cnt=0, Err=0, Err_code=00.
  - prev register=000, ovf_prev=0, state=SYNC.
  - Reset overrides every other event in the same cycle, including mid-fault and mid-step.
- Gray sequence: 000,001,011,010,110,111,101,100, then back to 000.
- State SYNC (first cycle after Reset deasserts):
  - Gray==000 and Ovf_in==0: go to TRACK, no pulse.
  - Otherwise: go to FAULT, Err_code=01.
- State TRACK, evaluated every cycle against prev. First matching rule wins:
  - Ovf_in != ovf_prev and the transition is not the 100->000 wrap: FAULT, code 11. This includes Ovf_in falling, since the counter only clears Overflow on Reset.
  - Gray==prev: hold; Step=0, Down=0.
  - Gray is the next code in the sequence:
    - Step=1 for exactly that cycle.
    - Bin<=gray2bin(Gray); prev<=Gray.
  - The 100->000 wrap additionally:
    - requires Ovf_in==1 in the same cycle, because the counter updates Output and Overflow on the same edge; if Ovf_in==0, FAULT code 11.
    - Wrap_cnt increments and holds at max when saturated. Step is still pulsed.
  - Any other change, including multi-bit jumps and backward steps without the macro: FAULT, code 10.
- State FAULT:
  - Err=1. Err_code holds its first cause; later anomalies never overwrite it.
  - Bin and Wrap_cnt frozen; Step=0, Down=0.
  - Exit only via Reset.
- Latency: Bin, Step, Down, Err and Wrap_cnt are valid one cycle after the Gray change is sampled (all outputs registered).
- ovf_prev<=Ovf_in every non-reset cycle.

Optional Feature:
- Macro GRAY_CHECKER_BIDIR_EN.
- Defined:
  - A single step to the previous code in the sequence is legal.
  - Down=1 for one cycle; Bin and prev update.
  - A backward 000->100 step is legal but Wrap_cnt does not change, and Ovf_in must not change.
- Undefined:
  - Any backward step is FAULT code 10.
  - Down is constant 0.

Decomposition:
- Package gray_pkg holds:
  - the eight Gray state constants (S0..S7);
  - FSM state encoding (SYNC, TRACK, FAULT);
  - error codes (ERR_NONE, ERR_START, ERR_JUMP, ERR_OVF).
- One combinational sub-module, gray2bin (3-bit Gray->binary: b2=g2, b1=b2^g1, b0=b1^g0). It is also used to derive the next and previous codes.

Test Plan:
- Reset, then Gray stepping 000->001->011 one step per cycle: Step pulses twice, Bin=1 then 2, Err=0.
- Full cycle to 100, then 000 with Ovf_in=1 on the same cycle: Step=1, Wrap_cnt=1, Bin=0, Err=0. Repeat 16 times with WRAP_W=4: Wrap_cnt saturates at 15.
- Gray 001->010 (two-bit jump): FAULT, Err=1, Err_code=10. Later Gray=011 leaves Bin=1 and Err_code=10 unchanged.
- Gray=000 with Ovf_in rising without a wrap: Err_code=11. Separately, a 100->000 wrap with Ovf_in=0: Err_code=11.
- Gray=011 in the first cycle after Reset: Err_code=01. Assert Reset mid-fault: all outputs return to 0 next cycle and the checker re-enters SYNC.
- With GRAY_CHECKER_BIDIR_EN, 011->001: Down=1, Bin=1, Err=0. Without the macro, the same stimulus gives Err_code=10.
